univ_shift_seq: RTL and testbench
=================================

// Module: univ_shift_seq
// PURPOSE
//  N-bit universal shift register with a multi-cycle shift sequencer: parallel load, logical/arithmetic
//  shift, rotate and bit-reverse, with a count-driven shift run and a start/busy/done handshake.
//  Successor to the 4-bit load/store shift register; serves as the datapath shifter and serial
//  (de)serialiser for the ALU and I/O blocks.
// PARAMETERS
//  N   8  register width in bits (N >= 2)
//  CW  4  width of count port; max run length 2**CW-1 cycles
// PORTS
//  clk    in   1    clock; all state changes on posedge
//  clr    in   1    asynchronous reset, active-low
//  set    in   1    synchronous preset, active-low: out <= all ones
//  start  in   1    command strobe, sampled only in IDLE
//  op     in   3    command opcode (table below), sampled with start
//  count  in   CW   number of 1-bit steps for shift/rotate ops, sampled with start
//  in     in   N    parallel load data, sampled with start
//  inLS   in   1    serial fill bit for SHL (enters bit 0)
//  inRS   in   1    serial fill bit for SHR (enters bit N-1)
//  out    out  N    register contents
//  shout  out  1    last bit shifted/rotated out of the register
//  busy   out  1    high while in RUN
//  done   out  1    one-cycle completion pulse
// BEHAVIOUR
//  Reset (clr=0, async): out=0, shout=0, busy=0, done=0, state=IDLE, internal cnt=0.
//  Priority each edge: clr > set > FSM. set=0: out<=all ones, state<=IDLE, busy<=0, done<=0,
//   shout unchanged; any run in progress is aborted with no done pulse.
//  op: 000 HOLD  001 LOAD (out<=in)  010 SHL (out<={out[N-2:0],inLS}, shout<=out[N-1])
//      011 SHR (out<={inRS,out[N-1:1]}, shout<=out[0])  100 ROL  101 ROR (shout<=bit moved)
//      110 ASR (out<={out[N-1],out[N-1:1]}, shout<=out[0])  111 REV (out<=bit-reversed out)
//  FSM states IDLE, RUN, DONE:
//   IDLE: start=0 -> stay, outputs held. start=1 with HOLD/LOAD/REV -> op applied on that edge,
//    go DONE. start=1 with shift/rotate op: count=0 -> no change, go DONE; count>0 -> latch op,
//    cnt<=count, go RUN (no shift on the start edge).
//   RUN: busy=1; each edge performs one step of latched op, cnt<=cnt-1; on the edge where cnt==1
//    the last step is performed and state<=DONE. Latency: exactly count RUN cycles.
//   DONE: done=1 for exactly one cycle, busy=0, then IDLE. start in DONE is ignored.
//  start, op, count, in are ignored in RUN and DONE (no queueing).
//  inLS/inRS are sampled live on every RUN edge (supports serial streaming); op/count are not.
//  count > N is legal: rotates wrap, shifts keep filling (SHL N+ steps with inLS=0 -> out=0).
//  ASR preserves sign for any count; ROL/ROR by N restores original value.
//  busy and done are registered outputs, never high together.
// TESTING (N=8, CW=4)
//  Reset: clr=0 mid-RUN -> out=00, busy=0, done=0 immediately (before next edge); restart OK.
//  LOAD: start,op=001,in=A5 -> next edge out=A5, following cycle done=1 for one cycle, busy never 1.
//  SHL run: out=81, op=010,count=3,inLS=1 -> busy 3 cycles, out=03,07,0F; shout=1,0,0; then done.
//  ROR by 8: out=3C, op=101,count=8 -> 8 busy cycles, final out=3C, done pulse; count=0 -> done, out unchanged.
//  ASR sign: out=90, op=110,count=2 -> out=C8 then E4; shout=0,0.
//  Abort/ignore: set=0 during RUN -> out=FF, IDLE, no done; start during RUN with op=001 -> ignored.

Source files
------------

// File: rtl/univ_shift_seq.sv
// univ_shift_seq: N-bit universal shift register driven by a small command
// sequencer. A command (op/count/in) is accepted on a start strobe in IDLE.
// HOLD, LOAD and REV complete on the start edge. Shift and rotate ops are
// latched and then stepped one bit per clock for `count` RUN cycles.
// Every command ends with a one-cycle done pulse in the DONE state.
//
// Handshake: start is sampled only in IDLE, together with op, count and in.
// busy is high for every RUN cycle. done is high for exactly the one cycle
// after the command finishes. busy and done are never high together, and
// start is ignored whenever the sequencer is not in IDLE.
//
// Ports:
//   clk        clock, all state changes on posedge
//   clr        asynchronous reset, active-low
//   set        synchronous preset, active-low (out <= all ones, abort run)
//   start      command strobe, sampled in IDLE
//   op[2:0]    command opcode
//   count      number of 1-bit steps for shift/rotate ops
//   in         parallel load data
//   inLS       serial fill bit for SHL (enters bit 0), sampled every RUN edge
//   inRS       serial fill bit for SHR (enters bit N-1), sampled every RUN edge
//   out        register contents
//   shout      last bit shifted/rotated out
//   busy       high while in RUN
//   done       one-cycle completion pulse
//   dbg_state  current sequencer state (IDLE=0, RUN=1, DONE=2)
module univ_shift_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          set,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [CW-1:0] count,
    input  logic [N-1:0]  in,
    input  logic          inLS,
    input  logic          inRS,
    output logic [N-1:0]  out,
    output logic          shout,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_REV  = 3'b111;

    state_t        state, state_n;
    logic [N-1:0]  out_n;
    logic          shout_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    op_q, op_q_n;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    // One 1-bit step of a shift/rotate op. Returns {shout, out}.
    function automatic logic [N:0] step(
        input logic [2:0]   o,
        input logic [N-1:0] v,
        input logic         sh,
        input logic         ls,
        input logic         rs
    );
        logic [N:0] r;
        r = {sh, v};
        case (o)
            OP_SHL:  r = {v[N-1], v[N-2:0], ls};
            OP_SHR:  r = {v[0], rs, v[N-1:1]};
            OP_ROL:  r = {v[N-1], v[N-2:0], v[N-1]};
            OP_ROR:  r = {v[0], v[0], v[N-1:1]};
            OP_ASR:  r = {v[0], v[N-1], v[N-1:1]};
            default: r = {sh, v};
        endcase
        return r;
    endfunction

    always_comb begin
        state_n = state;
        out_n   = out;
        shout_n = shout;
        cnt_n   = cnt;
        op_q_n  = op_q;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_HOLD: state_n = DONE;
                        OP_LOAD: begin
                            out_n   = in;
                            state_n = DONE;
                        end
                        OP_REV: begin
                            out_n   = bit_rev(out);
                            state_n = DONE;
                        end
                        default: begin
                            // A zero-length shift/rotate completes with no change.
                            if (count == '0) begin
                                state_n = DONE;
                            end else begin
                                op_q_n  = op;
                                cnt_n   = count;
                                state_n = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                {shout_n, out_n} = step(op_q, out, shout, inLS, inRS);
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            out   <= '0;
            shout <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_HOLD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (!set) begin
            // Preset aborts any run silently; shout keeps its last value.
            state <= IDLE;
            out   <= '1;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            out   <= out_n;
            shout <= shout_n;
            cnt   <= cnt_n;
            op_q  <= op_q_n;
            busy  <= (state_n == RUN);
            done  <= (state_n == DONE);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_univ_shift_seq.sv
module tb_univ_shift_seq;

    logic       clk;
    logic       clr;
    logic       set;
    logic       start;
    logic [2:0] op;
    logic [3:0] count;
    logic [7:0] in;
    logic       inLS;
    logic       inRS;
    logic [7:0] out;
    logic       shout;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int tests;
    int fails;

    // Reference state of the register as the bench expects it.
    logic [7:0] exp_out;
    logic       exp_shout;
    logic [7:0] exp_q[$];

    univ_shift_seq #(.N(8), .CW(4)) dut (
        .clk(clk), .clr(clr), .set(set), .start(start), .op(op),
        .count(count), .in(in), .inLS(inLS), .inRS(inRS), .out(out),
        .shout(shout), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_rev(input logic [7:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (((v >> i) & 1) != 0) r = r + (1 << (7 - i));
        end
        return r[7:0];
    endfunction

    // Applies one step of op to exp_out/exp_shout using plain arithmetic.
    task automatic model_step(input logic [2:0] o, input logic ls, input logic rs);
        int v;
        v = exp_out;
        case (o)
            3'd2: begin exp_shout = (v / 128) % 2; v = (v * 2 + ls) % 256; end
            3'd3: begin exp_shout = v % 2; v = v / 2 + rs * 128; end
            3'd4: begin exp_shout = (v / 128) % 2; v = (v * 2) % 256 + v / 128; end
            3'd5: begin exp_shout = v % 2; v = v / 2 + (v % 2) * 128; end
            3'd6: begin exp_shout = v % 2; v = v / 2 + (v / 128) * 128; end
            default: ;
        endcase
        exp_out = v[7:0];
    endtask

    // ---------------- driver ----------------
    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_cmd(input logic [2:0] o, input logic [3:0] c, input logic [7:0] d,
                           input bit fixed, input logic fls, input logic frs, input bit poke);
        bit is_run;
        logic ls, rs;
        is_run = (o >= 3'd2) && (o <= 3'd6) && (c != 4'd0);
        start = 1'b1; op = o; count = c; in = d;
        inLS = $urandom_range(0, 1); inRS = $urandom_range(0, 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = $urandom_range(0, 7); in = $urandom_range(0, 255);
        count = $urandom_range(0, 15);
        if (!is_run) begin
            if (o == 3'd1) exp_out = d;
            else if (o == 3'd7) exp_out = ref_rev(exp_out);
        end else begin
            for (int k = 0; k < c; k++) begin
                tests++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL run_busy op=%0d step=%0d busy=%b done=%b want busy=1 done=0", o, k, busy, done);
                end
                ls = fixed ? fls : 1'($urandom_range(0, 1));
                rs = fixed ? frs : 1'($urandom_range(0, 1));
                inLS = ls; inRS = rs;
                if (poke) begin
                    start = 1'b1; op = 3'd1; in = $urandom_range(0, 255);
                end
                model_step(o, ls, rs);
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                tests++;
                if (out !== exp_out || shout !== exp_shout) begin
                    fails++;
                    $display("FAIL run_step op=%0d step=%0d out=%h shout=%b want out=%h shout=%b",
                             o, k, out, shout, exp_out, exp_shout);
                end
            end
        end
        tests++;
        if (out !== exp_out || shout !== exp_shout || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse op=%0d cnt=%0d out=%h shout=%b done=%b busy=%b want out=%h shout=%b done=1 busy=0",
                     o, c, out, shout, done, busy, exp_out, exp_shout);
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (out !== exp_out || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL after_done op=%0d out=%h done=%b busy=%b want out=%h done=0 busy=0",
                     o, out, done, busy, exp_out);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b0; set = 1'b1; start = 1'b0; op = 3'd0; count = 4'd0;
        in = 8'd0; inLS = 1'b0; inRS = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (out !== 8'h00 || shout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state out=%h shout=%b busy=%b done=%b want 00 0 0 0", out, shout, busy, done);
        end
        clr = 1'b1;
        exp_out = 8'h00; exp_shout = 1'b0;
        // Asynchronous reset in the middle of a run.
        run_cmd(3'd1, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; op = 3'd4; count = 4'd9;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        clr = 1'b0;
        #1;
        tests++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || shout !== 1'b0) begin
            fails++;
            $display("FAIL async_clr out=%h busy=%b done=%b shout=%b want 00 0 0 0", out, busy, done, shout);
        end
        @(negedge clk);
        clr = 1'b1;
        exp_out = 8'h00; exp_shout = 1'b0;
        run_cmd(3'd1, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load();
        run_cmd(3'd1, 4'd7, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (out !== 8'hA5) begin
            fails++;
            $display("FAIL load_value out=%h want a5", out);
        end
    endtask

    task automatic test_shl();
        run_cmd(3'd1, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q = '{8'h03, 8'h07, 8'h0F};
        run_cmd(3'd2, 4'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (out !== exp_q[2] || shout !== 1'b0) begin
            fails++;
            $display("FAIL shl_final out=%h shout=%b want %h 0", out, shout, exp_q[2]);
        end
        // Long SHL with zero fill empties the register.
        run_cmd(3'd2, 4'd12, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (out !== 8'h00) begin
            fails++;
            $display("FAIL shl_flush out=%h want 00", out);
        end
    endtask

    task automatic test_rotate();
        run_cmd(3'd1, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(3'd5, 4'd8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (out !== 8'h3C) begin
            fails++;
            $display("FAIL ror8 out=%h want 3c", out);
        end
        run_cmd(3'd5, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(3'd4, 4'd11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(3'd7, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_asr();
        run_cmd(3'd1, 4'd0, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(3'd6, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (out !== 8'hE4 || shout !== 1'b0) begin
            fails++;
            $display("FAIL asr_sign out=%h shout=%b want e4 0", out, shout);
        end
        run_cmd(3'd6, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (out !== 8'hFF) begin
            fails++;
            $display("FAIL asr_saturate out=%h want ff", out);
        end
    endtask

    task automatic test_abort();
        // start with LOAD during a run must be ignored.
        run_cmd(3'd1, 4'd0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(3'd3, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        // Preset during a run: all ones, no done pulse.
        start = 1'b1; op = 3'd2; count = 4'd6; inLS = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model_step(3'd2, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        model_step(3'd2, 1'b0, 1'b0);
        set = 1'b0;
        @(posedge clk);
        @(negedge clk);
        set = 1'b1;
        exp_out = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (out !== exp_out || shout !== exp_shout || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL set_abort cyc=%0d out=%h shout=%b busy=%b done=%b want ff %b 0 0",
                         k, out, shout, busy, done, exp_shout);
            end
            @(negedge clk);
        end
        run_cmd(3'd3, 4'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] o;
        for (int i = 0; i < 60; i++) begin
            o = $urandom_range(0, 7);
            run_cmd(o, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0,
                    1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_out = 8'h00;
        exp_shout = 1'b0;
        test_reset();
        test_load();
        test_shl();
        test_rotate();
        test_asr();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
